// File: rtl/evp_pkg.sv
// Shared definitions for the EVP evaluate-polynomial child FSM: status codes, state and
// mode encodings, and default widths.
package evp_pkg;

   localparam int unsigned WORD_SIZE    = 16;
   localparam int unsigned N_SLOTS_LOG2 = 3;
   localparam int unsigned MAX_DEG_LOG2 = 5;
   localparam int unsigned ACC_WIDTH    = 2 * WORD_SIZE;
   localparam int unsigned FULL_WIDTH   = 3 * WORD_SIZE;
   localparam int unsigned ADDR_WIDTH   = N_SLOTS_LOG2 + MAX_DEG_LOG2;

   localparam logic [1:0] ST_OK     = 2'b00;
   localparam logic [1:0] ST_OVF    = 2'b01;
   localparam logic [1:0] ST_NOSLOT = 2'b10;

   typedef enum logic [2:0] {
      MODE_GET_COMMAND = 3'd0,
      MODE_STP         = 3'd1,
      MODE_EVP         = 3'd2,
      MODE_EVB         = 3'd3,
      MODE_RST         = 3'd4
   } mode_e;

   typedef enum logic [2:0] {
      StIdle,
      StWaitX,
      StRdTop,
      StLoad,
      StRd,
      StMac,
      StOut,
      StDone
   } evp_state_e;

endpackage

// File: rtl/horner_mac.sv
// One Horner step: acc*x + coef at full precision, wrapped to the accumulator width,
// with a flag when the exact sum does not fit the accumulator.
module horner_mac #(
   parameter int unsigned word_size = 16
) (
   input  logic [2*word_size-1:0] acc,
   input  logic [word_size-1:0]   x,
   input  logic [word_size-1:0]   coef,
   output logic [2*word_size-1:0] sum,
   output logic                   ovf
);

   localparam int unsigned AW = 2 * word_size;
   localparam int unsigned FW = 3 * word_size;

   logic [FW-1:0] acc_ext;
   logic [FW-1:0] x_ext;
   logic [FW-1:0] coef_ext;
   logic [FW-1:0] prod;
   logic [FW-1:0] full;
   logic [word_size:0] top;

   always_comb begin
      acc_ext  = {{word_size{acc[AW-1]}}, acc};
      x_ext    = {{AW{x[word_size-1]}}, x};
      coef_ext = {{AW{coef[word_size-1]}}, coef};
      // Low FW bits of the product are sign-correct because both operands are sign-extended.
      prod     = acc_ext * x_ext;
      full     = prod + coef_ext;
      sum      = full[AW-1:0];
      top      = full[FW-1:AW-1];
      ovf      = !((&top) || !(|top));
   end

endmodule

// File: rtl/evp_horner_fsm.sv
// EVP firing-mode child FSM: pops x, evaluates slot A's polynomial by Horner's rule from the
// coefficient RAM, writes one result/status pair and pulses done.
module evp_horner_fsm
   import evp_pkg::*;
#(
   parameter int unsigned word_size    = 16,
   parameter int unsigned n_slots_log2 = 3,
   parameter int unsigned max_deg_log2 = 5
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [n_slots_log2-1:0]              slot_a,
   input  logic [max_deg_log2-1:0]              slot_n,
   input  logic                                 slot_valid,
   input  logic [word_size-1:0]                 data_in,
   input  logic                                 data_empty,
   output logic                                 rd_in_data,
   output logic [n_slots_log2+max_deg_log2-1:0] coef_addr,
   output logic                                 coef_rd_en,
   input  logic [word_size-1:0]                 coef_data,
   input  logic                                 out_full,
   output logic                                 wr_out,
   output logic [2*word_size-1:0]               result,
   output logic [1:0]                           status,
   output logic                                 busy,
   output logic                                 done
);

   localparam int unsigned AW = 2 * word_size;

   evp_state_e                state_q, state_d;
   logic [n_slots_log2-1:0]   a_q, a_d;
   logic [max_deg_log2-1:0]   n_q, n_d;
   logic [max_deg_log2-1:0]   idx_q, idx_d;
   logic                      valid_q, valid_d;
   logic [word_size-1:0]      x_q, x_d;
   logic [AW-1:0]             acc_q, acc_d;
   logic                      ovf_q, ovf_d;
   logic [AW-1:0]             mac_sum;
   logic                      mac_ovf;

   horner_mac #(
      .word_size(word_size)
   ) u_mac (
      .acc (acc_q),
      .x   (x_q),
      .coef(coef_data),
      .sum (mac_sum),
      .ovf (mac_ovf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         n_q     <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         x_q     <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         x_q     <= x_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      n_d        = n_q;
      idx_d      = idx_q;
      valid_d    = valid_q;
      x_d        = x_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      rd_in_data = 1'b0;
      coef_rd_en = 1'b0;
      coef_addr  = '0;
      wr_out     = 1'b0;
      result     = '0;
      status     = ST_OK;
      busy       = (state_q != StIdle);
      done       = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = slot_a;
               n_d     = slot_n;
               valid_d = slot_valid;
               state_d = StWaitX;
            end
         end
         StWaitX: begin
            if (!data_empty) begin
               rd_in_data = 1'b1;
               x_d        = data_in;
               if (!valid_q) begin
                  // Unprogrammed slot: report zero without touching the RAM.
                  acc_d   = '0;
                  ovf_d   = 1'b0;
                  state_d = StOut;
               end else begin
                  state_d = StRdTop;
               end
            end
         end
         StRdTop: begin
            coef_rd_en = 1'b1;
            coef_addr  = {a_q, n_q};
            idx_d      = n_q;
            state_d    = StLoad;
         end
         StLoad: begin
            acc_d = {{word_size{coef_data[word_size-1]}}, coef_data};
            ovf_d = 1'b0;
            if (idx_q == '0) begin
               state_d = StOut;
            end else begin
               idx_d   = idx_q - 1'b1;
               state_d = StRd;
            end
         end
         StRd: begin
            coef_rd_en = 1'b1;
            coef_addr  = {a_q, idx_q};
            state_d    = StMac;
         end
         StMac: begin
            acc_d = mac_sum;
            ovf_d = ovf_q | mac_ovf;
            if (idx_q == '0) begin
               state_d = StOut;
            end else begin
               idx_d   = idx_q - 1'b1;
               state_d = StRd;
            end
         end
         StOut: begin
            result = acc_q;
            status = !valid_q ? ST_NOSLOT : (ovf_q ? ST_OVF : ST_OK);
            if (!out_full) begin
               wr_out  = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_evp_horner_fsm.sv
// Randomized self-checking bench for evp_horner_fsm against a plain-arithmetic Horner model.
module tb_evp_horner_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  slot_a;
   logic [4:0]  slot_n;
   logic        slot_valid;
   logic [15:0] data_in;
   logic        data_empty;
   logic        rd_in_data;
   logic [7:0]  coef_addr;
   logic        coef_rd_en;
   logic [15:0] coef_data;
   logic        out_full;
   logic        wr_out;
   logic [31:0] result;
   logic [1:0]  status;
   logic        busy;
   logic        done;

   evp_horner_fsm dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .slot_a    (slot_a),
      .slot_n    (slot_n),
      .slot_valid(slot_valid),
      .data_in   (data_in),
      .data_empty(data_empty),
      .rd_in_data(rd_in_data),
      .coef_addr (coef_addr),
      .coef_rd_en(coef_rd_en),
      .coef_data (coef_data),
      .out_full  (out_full),
      .wr_out    (wr_out),
      .result    (result),
      .status    (status),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   logic [15:0] ram [0:255];
   always @(posedge clk) if (coef_rd_en) coef_data <= ram[coef_addr];

   int checks   = 0;
   int failures = 0;

   // Per-operation observations and model expectations.
   int          pops, pop_k, writes, wr_k, dones, done_k, unstable;
   bit          timed_out;
   logic [7:0]  rd_addr [$];
   logic [31:0] wr_res, exp_res;
   logic [1:0]  wr_st, exp_st;

   function automatic void model(input logic [2:0] a, input logic [4:0] n, input bit valid,
                                 input logic [15:0] x, output logic [31:0] r,
                                 output logic [1:0] st);
      longint acc, v;
      bit     ovf;
      logic [4:0] ii;
      if (!valid) begin
         r  = 32'd0;
         st = 2'b10;
         return;
      end
      acc = longint'($signed(ram[{a, n}]));
      ovf = 1'b0;
      for (int i = int'(n) - 1; i >= 0; i--) begin
         ii  = i[4:0];
         v   = acc * longint'($signed(x)) + longint'($signed(ram[{a, ii}]));
         if (v < -(longint'(1) << 31) || v >= (longint'(1) << 31)) ovf = 1'b1;
         acc = longint'($signed(v[31:0]));
      end
      r  = acc[31:0];
      st = ovf ? 2'b01 : 2'b00;
   endfunction

   // Runs one start..done transaction; cycle k=0 is the cycle in which start is sampled.
   task automatic run_op(input logic [2:0] a, input logic [4:0] n, input bit valid,
                         input logic [15:0] x, input int empty_c, input int full_c,
                         input bit stray, input int tail);
      int out_start;
      model(a, n, valid, x, exp_res, exp_st);
      pops = 0; writes = 0; dones = 0; unstable = 0; timed_out = 1'b0;
      pop_k = -1; wr_k = -1; done_k = -1;
      rd_addr.delete();
      out_start = (valid ? 4 + 2 * int'(n) : 2) + empty_c;
      for (int k = 0; ; k++) begin
         @(posedge clk);
         #1;
         start      = (k == 0) || (stray && k == 2);
         slot_a     = (k == 0) ? a : 3'($urandom);
         slot_n     = (k == 0) ? n : 5'($urandom);
         slot_valid = (k == 0) ? valid : 1'($urandom);
         data_in    = (k == 0) ? x : data_in;
         data_empty = (k >= 1 && k < 1 + empty_c);
         out_full   = (k >= out_start && k < out_start + full_c);
         @(negedge clk);
         if (rd_in_data) begin pops++; pop_k = k; end
         if (coef_rd_en) rd_addr.push_back(coef_addr);
         if (wr_out) begin writes++; wr_k = k; wr_res = result; wr_st = status; end
         if (done) begin dones++; done_k = k; end
         if (out_full && (wr_out || result !== exp_res || status !== exp_st)) unstable++;
         if (dones > 0 && k >= done_k + tail) break;
         if (k > 400) begin timed_out = 1'b1; break; end
      end
      start = 1'b0; data_empty = 1'b1; out_full = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({rd_in_data, coef_rd_en, coef_addr, wr_out, result, status, busy, done} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got %0h required 0",
                  {rd_in_data, coef_rd_en, coef_addr, wr_out, result, status, busy, done});
      end
   endtask

   task automatic test_basic();
      logic [7:0] ea;
      ram[{3'd3, 5'd0}] = 16'd1; ram[{3'd3, 5'd1}] = 16'd2; ram[{3'd3, 5'd2}] = 16'd3;
      run_op(3'd3, 5'd2, 1'b1, 16'd2, 0, 0, 1'b0, 2);
      checks++; if (timed_out) begin failures++; $display("FAIL basic_timeout: got timeout required done"); end
      checks++; if (pop_k !== 1) begin failures++; $display("FAIL basic_pop_cycle: got %0d required 1", pop_k); end
      checks++; if (wr_k !== 8) begin failures++; $display("FAIL basic_wr_cycle: got %0d required 8", wr_k); end
      checks++; if (done_k !== 9) begin failures++; $display("FAIL basic_done_cycle: got %0d required 9", done_k); end
      checks++; if (wr_res !== 32'd17) begin failures++; $display("FAIL basic_result: got %0d required 17", wr_res); end
      checks++; if (wr_st !== 2'b00) begin failures++; $display("FAIL basic_status: got %b required 00", wr_st); end
      checks++;
      if (rd_addr.size() !== 3) begin
         failures++; $display("FAIL basic_read_count: got %0d required 3", rd_addr.size());
      end else begin
         for (int j = 0; j < 3; j++) begin
            ea = {3'd3, 5'(2 - j)};
            if (rd_addr[j] !== ea) begin
               failures++; $display("FAIL basic_read_addr: got %0h required %0h", rd_addr[j], ea);
            end
         end
      end
   endtask

   task automatic test_signed();
      ram[{3'd1, 5'd0}] = 16'd5; ram[{3'd1, 5'd1}] = 16'hFFFD; ram[{3'd1, 5'd2}] = 16'd2;
      run_op(3'd1, 5'd2, 1'b1, 16'hFFFF, 0, 0, 1'b0, 2);
      checks++; if (wr_res !== 32'd10) begin failures++; $display("FAIL signed_result: got %0h required a", wr_res); end
      checks++; if (wr_st !== 2'b00) begin failures++; $display("FAIL signed_status: got %b required 00", wr_st); end
   endtask

   task automatic test_overflow();
      for (int j = 0; j < 4; j++) ram[{3'd2, 5'(j)}] = 16'h7FFF;
      run_op(3'd2, 5'd3, 1'b1, 16'h7FFF, 0, 0, 1'b0, 2);
      checks++; if (wr_st !== 2'b01) begin failures++; $display("FAIL ovf_status: got %b required 01", wr_st); end
      checks++; if (wr_res !== exp_res) begin failures++; $display("FAIL ovf_result: got %0h required %0h", wr_res, exp_res); end
      checks++; if (writes !== 1) begin failures++; $display("FAIL ovf_write_count: got %0d required 1", writes); end
   endtask

   task automatic test_noslot();
      run_op(3'd6, 5'd4, 1'b0, 16'd7, 0, 0, 1'b0, 2);
      checks++; if (pop_k !== 1) begin failures++; $display("FAIL noslot_pop_cycle: got %0d required 1", pop_k); end
      checks++; if (rd_addr.size() !== 0) begin failures++; $display("FAIL noslot_reads: got %0d required 0", rd_addr.size()); end
      checks++; if (wr_res !== 32'd0 || wr_st !== 2'b10) begin
         failures++; $display("FAIL noslot_output: got %0h/%b required 0/10", wr_res, wr_st);
      end
      checks++; if (wr_k !== 2 || done_k !== 3) begin
         failures++; $display("FAIL noslot_timing: got wr %0d done %0d required 2/3", wr_k, done_k);
      end
   endtask

   task automatic test_stall();
      ram[{3'd5, 5'd0}] = 16'h1234;
      run_op(3'd5, 5'd0, 1'b1, 16'h0042, 4, 5, 1'b0, 2);
      checks++; if (pops !== 1 || pop_k !== 5) begin
         failures++; $display("FAIL stall_pop: got %0d pops at %0d required 1 at 5", pops, pop_k);
      end
      checks++; if (unstable !== 0) begin failures++; $display("FAIL stall_hold: got %0d bad cycles required 0", unstable); end
      checks++; if (wr_k !== 13 || wr_res !== 32'h00001234) begin
         failures++; $display("FAIL stall_write: got %0h at %0d required 1234 at 13", wr_res, wr_k);
      end
      checks++; if (dones !== 1 || done_k !== 14) begin
         failures++; $display("FAIL stall_done: got %0d at %0d required 1 at 14", dones, done_k);
      end
   endtask

   task automatic test_reset_abort();
      int bad;
      for (int j = 0; j < 6; j++) ram[{3'd4, 5'(j)}] = 16'($urandom);
      slot_a = 3'd4; slot_n = 5'd5; slot_valid = 1'b1; data_in = 16'd9;
      data_empty = 1'b0; out_full = 1'b0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({rd_in_data, coef_rd_en, coef_addr, wr_out, result, status, busy, done} !== '0) begin
         failures++; $display("FAIL abort_outputs: got %0h required 0",
                              {rd_in_data, coef_rd_en, coef_addr, wr_out, result, status, busy, done});
      end
      #1 rst = 1'b0;
      bad = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (wr_out || done || busy || rd_in_data || coef_rd_en) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL abort_quiet: got %0d active cycles required 0", bad); end
      ram[{3'd4, 5'd0}] = 16'd4; ram[{3'd4, 5'd1}] = 16'd3;
      run_op(3'd4, 5'd1, 1'b1, 16'd3, 0, 0, 1'b0, 2);
      checks++; if (wr_res !== 32'd13 || wr_st !== 2'b00) begin
         failures++; $display("FAIL abort_restart: got %0d/%b required 13/00", wr_res, wr_st);
      end
   endtask

   task automatic test_random();
      logic [2:0]  a;
      logic [4:0]  n;
      bit          v;
      int          e, f, ew;
      logic [7:0]  ea;
      for (int t = 0; t < 24; t++) begin
         a = 3'($urandom); n = 5'($urandom); v = ($urandom_range(0, 9) != 0);
         e = $urandom_range(0, 3); f = $urandom_range(0, 3);
         for (int j = 0; j < 32; j++) ram[{a, 5'(j)}] = 16'($urandom);
         run_op(a, n, v, 16'($urandom), e, f, 1'($urandom), 2);
         ew = (v ? 4 + 2 * int'(n) : 2) + e + f;
         checks++; if (wr_res !== exp_res || wr_st !== exp_st) begin
            failures++; $display("FAIL rand_output[%0d]: got %0h/%b required %0h/%b",
                                 t, wr_res, wr_st, exp_res, exp_st);
         end
         checks++; if (pops !== 1 || writes !== 1 || dones !== 1) begin
            failures++; $display("FAIL rand_counts[%0d]: got %0d/%0d/%0d required 1/1/1",
                                 t, pops, writes, dones);
         end
         checks++; if (pop_k !== 1 + e || wr_k !== ew || done_k !== ew + 1) begin
            failures++; $display("FAIL rand_timing[%0d]: got %0d/%0d/%0d required %0d/%0d/%0d",
                                 t, pop_k, wr_k, done_k, 1 + e, ew, ew + 1);
         end
         checks++;
         if (rd_addr.size() !== (v ? int'(n) + 1 : 0)) begin
            failures++; $display("FAIL rand_reads[%0d]: got %0d reads", t, rd_addr.size());
         end else begin
            for (int j = 0; j < rd_addr.size(); j++) begin
               ea = {a, 5'(int'(n) - j)};
               if (rd_addr[j] !== ea) begin
                  failures++; $display("FAIL rand_read_addr[%0d]: got %0h required %0h", t, rd_addr[j], ea);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 3; t++) begin
         ram[{3'd7, 5'd0}] = 16'(t + 1); ram[{3'd7, 5'd1}] = 16'd2;
         run_op(3'd7, 5'd1, 1'b1, 16'(t), 0, 0, 1'b0, 0);
         checks++; if (wr_res !== 32'(2 * t + t + 1) || wr_k !== 6 || done_k !== 7) begin
            failures++; $display("FAIL b2b[%0d]: got %0d at %0d required %0d at 6",
                                 t, wr_res, wr_k, 2 * t + t + 1);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; slot_a = '0; slot_n = '0; slot_valid = 1'b0;
      data_in = '0; data_empty = 1'b1; out_full = 1'b0;
      for (int j = 0; j < 256; j++) ram[j] = '0;
      #12;
      test_reset();
      @(negedge clk) rst = 1'b0;
      test_basic();
      test_signed();
      test_overflow();
      test_noslot();
      test_stall();
      test_reset_abort();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
